// File: rtl/xtea_stream_ctrl.sv
// Word-stream wrapper for an XTEA core: packs 4x32b words into a block, runs the core, then unpacks the result (ECB, or CBC under XTEA_CBC_EN).
// Latency: out_valid rises 2 cycles after core_ready; in_ready is low outside FILL, and out_data holds while out_ready is low.
module xtea_stream_ctrl (
  input  logic         clock,
  input  logic         reset,
  input  logic         cfg,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         chain_load,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [31:0]  out_data,
  input  logic         out_ready,
  output logic         core_start,
  output logic         core_cfg,
  output logic [127:0] core_key,
  output logic [127:0] core_data_i,
  input  logic         core_ready,
  input  logic [127:0] core_data_o,
  output logic         busy
);

  typedef enum logic [2:0] {FILL, START, WAIT, CAPT, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q;
  logic [127:0] blk_q;
  logic [127:0] res_q;
  logic [127:0] ci_q;
  logic         core_cfg_q;
  logic [127:0] core_key_q;

  logic         accept;
  logic         deliver;
  logic [127:0] blk_next;
  logic [127:0] ci_next;
  logic [127:0] res_next;

  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;
  assign blk_next = {blk_q[95:0], in_data};

`ifdef XTEA_CBC_EN
  logic [127:0] chain_q;
  logic [127:0] chain_capt;

  // core_cfg_q is already the block's direction by the time word 3 arrives
  assign ci_next    = core_cfg_q ? (blk_next ^ chain_q) : blk_next;
  assign res_next   = core_cfg_q ? core_data_o : (core_data_o ^ chain_q);
  assign chain_capt = core_cfg_q ? core_data_o : blk_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else if (state_q == FILL && cnt_q == 2'd0 && chain_load) begin
      chain_q <= iv;
    end else if (state_q == CAPT) begin
      chain_q <= chain_capt;
    end
  end
`else
  logic unused_cbc;
  assign unused_cbc = ^{iv, chain_load};
  assign ci_next    = blk_next;
  assign res_next   = core_data_o;
`endif

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    core_start = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (accept && cnt_q == 2'd3) state_d = START;
      end
      START: begin
        core_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_ready) state_d = CAPT;
      end
      CAPT: begin
        state_d = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (deliver && cnt_q == 2'd3) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      cnt_q      <= 2'd0;
      blk_q      <= '0;
      res_q      <= '0;
      ci_q       <= '0;
      core_cfg_q <= 1'b0;
      core_key_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        blk_q <= blk_next;
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          core_cfg_q <= cfg;
          core_key_q <= key;
        end
        if (cnt_q == 2'd3) ci_q <= ci_next;
      end
      if (deliver) cnt_q <= cnt_q + 2'd1;
      // core drives its result one cycle after ready, i.e. during CAPT
      if (state_q == CAPT) res_q <= res_next;
    end
  end

  always_comb begin
    out_data = 32'd0;
    if (out_valid) begin
      case (cnt_q)
        2'd0:    out_data = res_q[127:96];
        2'd1:    out_data = res_q[95:64];
        2'd2:    out_data = res_q[63:32];
        default: out_data = res_q[31:0];
      endcase
    end
  end

  assign core_cfg    = core_cfg_q;
  assign core_key    = core_key_q;
  assign core_data_i = ci_q;
  assign busy        = !(state_q == FILL && cnt_q == 2'd0);

endmodule

// File: tb/tb_xtea_stream_ctrl.sv
// Bench for xtea_stream_ctrl: stub core (ready 32 cycles after start, result = ~input) and a block-level reference model.
module tb_xtea_stream_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cfg = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic         chain_load = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready = 1'b0;
  logic         core_start;
  logic         core_cfg;
  logic [127:0] core_key;
  logic [127:0] core_data_i;
  logic         core_ready = 1'b0;
  logic [127:0] core_data_o = '0;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  xtea_stream_ctrl dut (
    .clock(clock), .reset(reset), .cfg(cfg), .key(key), .iv(iv), .chain_load(chain_load),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_start(core_start), .core_cfg(core_cfg), .core_key(core_key),
    .core_data_i(core_data_i), .core_ready(core_ready), .core_data_o(core_data_o),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Stub cipher core
  int timer = 0;
  always @(posedge clock) begin
    core_ready <= 1'b0;
    if (core_ready) core_data_o <= ~core_data_i;
    if (core_start) timer <= 32;
    else if (timer != 0) begin
      timer <= timer - 1;
      if (timer == 1) core_ready <= 1'b1;
    end
  end

  // What the core was handed at each start
  int           n_starts = 0;
  logic [127:0] st_ci = '0;
  logic         st_cfg = 1'b0;
  logic [127:0] st_key = '0;
  always @(posedge clock) begin
    if (core_start) begin
      n_starts = n_starts + 1;
      st_ci    = core_data_i;
      st_cfg   = core_cfg;
      st_key   = core_key;
    end
  end

  // Reference model: chaining value seen by the next block
  logic [127:0] m_chain = '0;

  task automatic model_block(input logic [127:0] blk, input logic c0, input logic ld,
                             input logic [127:0] ivv,
                             output logic [127:0] exp_ci, output logic [127:0] exp_out);
`ifdef XTEA_CBC_EN
    if (ld) m_chain = ivv;
    if (c0) begin
      exp_ci  = blk ^ m_chain;
      exp_out = ~exp_ci;
      m_chain = exp_out;
    end else begin
      exp_ci  = blk;
      exp_out = (~blk) ^ m_chain;
      m_chain = blk;
    end
`else
    exp_ci  = blk;
    exp_out = ~blk;
    if (ld && ivv == 128'd1) m_chain = m_chain;
`endif
  endtask

  task automatic push_block(input logic [127:0] blk, input logic c0, input logic crest,
                            input logic [127:0] k, input logic ld, input logic [127:0] ivv,
                            output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int waited = 0;
      @(negedge clock);
      in_valid   = 1'b1;
      in_data    = blk[127-32*i -: 32];
      cfg        = (i == 0) ? c0 : crest;
      key        = (i == 0) ? k : ~k;
      chain_load = (i == 0) && ld;
      iv         = ivv;
      while (!in_ready && waited < 200) begin
        @(negedge clock);
        waited++;
      end
      if (!in_ready) timed_out = 1'b1;
      @(posedge clock);
    end
    @(negedge clock);
    in_valid   = 1'b0;
    chain_load = 1'b0;
    cfg        = crest;
  endtask

  task automatic pull_block(input bit bp, output logic [127:0] got, output bit timed_out);
    int j = 0;
    int cyc = 0;
    got = '0;
    timed_out = 1'b0;
    while (j < 4 && cyc < 400) begin
      @(negedge clock);
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid && out_ready) begin
        got[127-32*j -: 32] = out_data;
        j++;
      end
      cyc++;
    end
    if (j < 4) timed_out = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [293:0] obs;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    obs = {in_ready, out_valid, out_data, core_start, core_cfg, core_key, core_data_i, busy};
    vectors++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0, 128'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got %h want in_ready=1 rest 0", obs);
    end
    reset = 1'b0;
    m_chain = '0;
  endtask

  task automatic test_ecb_vector();
    logic [127:0] blk, eci, eout, got;
    bit t0, t1;
    int s0;
    blk = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    model_block(blk, 1'b1, 1'b0, '0, eci, eout);
    s0 = n_starts;
    push_block(blk, 1'b1, 1'b1, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 1'b0, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if ((t0 | t1) !== 1'b0) begin miscompares++; $display("FAIL vec_timeout: got %0b%0b want 00", t0, t1); end
    vectors++;
    if (got !== 128'hFEDCBA98_76543210_01234567_89ABCDEF) begin
      miscompares++; $display("FAIL vec_output: got %h want FEDCBA98_76543210_01234567_89ABCDEF", got);
    end
    vectors++;
    if (n_starts - s0 !== 1) begin miscompares++; $display("FAIL vec_start_pulses: got %0d want 1", n_starts - s0); end
    vectors++;
    if (st_cfg !== 1'b1) begin miscompares++; $display("FAIL vec_core_cfg: got %0b want 1", st_cfg); end
    vectors++;
    if (st_key !== 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff) begin
      miscompares++; $display("FAIL vec_core_key: got %h want 00112233...eeff", st_key);
    end
    vectors++;
    if (st_ci !== eci) begin miscompares++; $display("FAIL vec_core_data_i: got %h want %h", st_ci, eci); end
  endtask

  task automatic test_backpressure();
    logic [127:0] blk, eci, eout, got;
    bit t0, t1;
    int waited = 0;
    int bad = 0;
    blk = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    model_block(blk, 1'b1, 1'b0, '0, eci, eout);
    push_block(blk, 1'b1, 1'b1, 128'h5, 1'b0, '0, t0);
    out_ready = 1'b0;
    while (!out_valid && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid_rise: got %0b want 1", out_valid); end
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if ({out_valid, out_data, in_ready} !== {1'b1, eout[127:96], 1'b0}) begin
        miscompares++; bad++;
        $display("FAIL bp_hold cycle %0d: got valid=%0b data=%h in_ready=%0b want 1 %h 0",
                 c, out_valid, out_data, in_ready, eout[127:96]);
      end
      @(negedge clock);
    end
    pull_block(1'b1, got, t1);
    vectors++;
    if (got !== 128'hFEDCBA98_76543210_01234567_89ABCDEF || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL bp_output: got %h to=%0b%0b want FEDCBA98_76543210_01234567_89ABCDEF", got, t0, t1);
    end
  endtask

  task automatic test_cfg_sample();
    logic [127:0] blk, eci, eout, got;
    bit t0, t1;
    blk = {$urandom, $urandom, $urandom, $urandom};
    model_block(blk, 1'b1, 1'b0, '0, eci, eout);
    push_block(blk, 1'b1, 1'b0, 128'hA, 1'b0, '0, t0);
    vectors++;
    if ({busy, core_cfg} !== 2'b11) begin miscompares++; $display("FAIL cfg_hold_busy: got busy=%0b core_cfg=%0b want 1 1", busy, core_cfg); end
    pull_block(1'b0, got, t1);
    vectors++;
    if (got !== eout || st_cfg !== 1'b1 || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL cfg_block1: got %h cfg=%0b want %h cfg=1", got, st_cfg, eout);
    end
    blk = {$urandom, $urandom, $urandom, $urandom};
    model_block(blk, 1'b0, 1'b0, '0, eci, eout);
    push_block(blk, 1'b0, 1'b0, 128'hB, 1'b0, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if (got !== eout || st_cfg !== 1'b0 || st_ci !== eci || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL cfg_block2: got %h cfg=%0b ci=%h want %h cfg=0 ci=%h", got, st_cfg, st_ci, eout, eci);
    end
  endtask

  task automatic test_reset_mid_block();
    logic [127:0] blk, eci, eout, got;
    logic [293:0] obs;
    bit t0, t1;
    int seen = 0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    push_block(blk, 1'b1, 1'b1, 128'hC, 1'b0, '0, t0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    #1;
    obs = {in_ready, out_valid, out_data, core_start, core_cfg, core_key, core_data_i, busy};
    vectors++;
    if (obs !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 128'd0, 128'd0, 1'b0}) begin
      miscompares++; $display("FAIL midreset_values: got %h want in_ready=1 rest 0", obs);
    end
    @(negedge clock);
    reset = 1'b0;
    m_chain = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midreset_no_output: got %0d valid cycles want 0", seen); end
    blk = {$urandom, $urandom, $urandom, $urandom};
    model_block(blk, 1'b1, 1'b0, '0, eci, eout);
    push_block(blk, 1'b1, 1'b1, 128'hD, 1'b0, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if (got !== eout || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL midreset_recover: got %h want %h", got, eout);
    end
  endtask

`ifdef XTEA_CBC_EN
  task automatic test_cbc();
    logic [127:0] eci, eout, got;
    bit t0, t1;
    @(negedge clock);
    chain_load = 1'b1;
    iv = {128{1'b1}};
    @(negedge clock);
    chain_load = 1'b0;
    m_chain = {128{1'b1}};
    model_block('0, 1'b1, 1'b0, '0, eci, eout);
    push_block('0, 1'b1, 1'b1, 128'hE, 1'b0, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if (st_ci !== {128{1'b1}} || got !== 128'd0 || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL cbc_enc_blk1: got ci=%h out=%h want ci=all-ones out=0", st_ci, got);
    end
    model_block('0, 1'b1, 1'b0, '0, eci, eout);
    push_block('0, 1'b1, 1'b1, 128'hE, 1'b0, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if (st_ci !== 128'd0 || got !== {128{1'b1}} || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL cbc_enc_blk2: got ci=%h out=%h want ci=0 out=all-ones", st_ci, got);
    end
    model_block('0, 1'b0, 1'b1, '0, eci, eout);
    push_block('0, 1'b0, 1'b0, 128'hF, 1'b1, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if (st_ci !== 128'd0 || got !== {128{1'b1}} || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL cbc_dec_iv0: got ci=%h out=%h want ci=0 out=all-ones", st_ci, got);
    end
    model_block('0, 1'b0, 1'b0, '0, eci, eout);
    push_block('0, 1'b0, 1'b0, 128'hF, 1'b0, '0, t0);
    pull_block(1'b0, got, t1);
    vectors++;
    if (got !== {128{1'b1}} || (t0 | t1) !== 1'b0) begin
      miscompares++; $display("FAIL cbc_dec_chain0: got out=%h want all-ones", got);
    end
  endtask
`endif

  task automatic test_random();
    logic [127:0] blk, k, ivv, eci, eout, got;
    logic c0, crest, ld;
    bit t0, t1;
    int s0;
    for (int n = 0; n < 16; n++) begin
      blk   = {$urandom, $urandom, $urandom, $urandom};
      k     = {$urandom, $urandom, $urandom, $urandom};
      ivv   = {$urandom, $urandom, $urandom, $urandom};
      c0    = 1'($urandom_range(0, 1));
      crest = 1'($urandom_range(0, 1));
      ld    = ($urandom_range(0, 3) == 0);
      model_block(blk, c0, ld, ivv, eci, eout);
      s0 = n_starts;
      push_block(blk, c0, crest, k, ld, ivv, t0);
      pull_block(1'b1, got, t1);
      vectors++;
      if (got !== eout || (t0 | t1) !== 1'b0) begin
        miscompares++; $display("FAIL rand_output[%0d]: got %h want %h", n, got, eout);
      end
      vectors++;
      if (st_ci !== eci || st_cfg !== c0 || st_key !== k || n_starts - s0 !== 1) begin
        miscompares++;
        $display("FAIL rand_core[%0d]: got ci=%h cfg=%0b starts=%0d want ci=%h cfg=%0b starts=1",
                 n, st_ci, st_cfg, n_starts - s0, eci, c0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ecb_vector();
    test_backpressure();
    test_cfg_sample();
    test_reset_mid_block();
`ifdef XTEA_CBC_EN
    test_cbc();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
